shifter_sched: RTL and testbench

SHIFTER_SCHED -- requirements
Module: shifter_sched

---
 rtl/shifter_sched_pkg.sv | 15 +
 rtl/shifter_sched_if.sv | 31 +++
 rtl/shifter_sched_shifter.sv | 35 +++
 rtl/shifter_sched.sv | 143 ++++++++++++++
 tb/tb_shifter_sched.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/shifter_sched_pkg.sv
// Shared constants and helpers for the softmax exponent path.
// Holds the FP32 bias, the default exponent limit and the id-width helper.
package shifter_sched_pkg;

  localparam logic [7:0] FP32_BIAS    = 8'h7f;
  localparam int         INPUTMAX_DEF = 5;

  typedef logic [1:0] credit_t;
  localparam credit_t CREDIT_MAX = 2'd2;

  function automatic int id_w(input int nreq);
    return (nreq <= 2) ? 1 : $clog2(nreq);
  endfunction

endpackage

// File: rtl/shifter_sched_if.sv
// Request/response bundle between requesters, the scheduler and its consumer.
// The slave side is the scheduler; the master side drives requests and Rsp_rdy.
interface shifter_sched_if
  import shifter_sched_pkg::*;
#(
  parameter int BITWIDTH = 32,
  parameter int NREQ     = 4
);
  localparam int IDW = id_w(NREQ);

  logic [NREQ-1:0]          Req_vld;
  logic [NREQ*BITWIDTH-1:0] Req_data;
  logic [NREQ-1:0]          Req_rdy;
  logic                     Rsp_vld;
  logic                     Rsp_rdy;
  logic [BITWIDTH-1:0]      Rsp_data;
  logic [IDW-1:0]           Rsp_id;
  logic                     Rsp_sat;
  logic                     Busy;

  modport master (
    output Req_vld, Req_data, Rsp_rdy,
    input  Req_rdy, Rsp_vld, Rsp_data, Rsp_id, Rsp_sat, Busy
  );

  modport slave (
    input  Req_vld, Req_data, Rsp_rdy,
    output Req_rdy, Rsp_vld, Rsp_data, Rsp_id, Rsp_sat, Busy
  );

endinterface

// File: rtl/shifter_sched_shifter.sv
// One-cycle shifter producing the IEEE-754 single-precision value 2^Datain.
// The exponent field is bias + Datain; the mantissa is zero.
module shifter_sched_shifter
  import shifter_sched_pkg::*;
#(
  parameter int BITWIDTH = 32,
  parameter int INPUTMAX = INPUTMAX_DEF
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                Start,
  input  logic [BITWIDTH-1:0] Datain,
  output logic [BITWIDTH-1:0] DataOut,
  output logic                DataOut_vld
);

  logic [7:0]  exp_p0;
  logic [31:0] pow2_p0;

  // Defensive limit: the exponent field never leaves the supported range.
  assign exp_p0  = (Datain > BITWIDTH'(INPUTMAX)) ? 8'(INPUTMAX) : Datain[7:0];
  assign pow2_p0 = {1'b0, FP32_BIAS + exp_p0, 23'd0};

  // ---- stage p0 -> p1 ----
  always_ff @(posedge Clock) begin
    if (Reset) begin
      DataOut     <= '0;
      DataOut_vld <= 1'b0;
    end else begin
      DataOut_vld <= Start;
      if (Start) DataOut <= BITWIDTH'(pow2_p0);
    end
  end

endmodule

// File: rtl/shifter_sched.sv
// Round-robin scheduler sharing one 2^E shifter among NREQ requesters.
// Credit-limited issue into a 2-entry response FIFO keeps responses in grant order.
module shifter_sched
  import shifter_sched_pkg::*;
#(
  parameter int BITWIDTH = 32,
  parameter int NREQ     = 4,
  parameter int INPUTMAX = INPUTMAX_DEF
) (
  input  logic           Clock,
  input  logic           Reset,
  shifter_sched_if.slave bus
);

  localparam int             IDW  = id_w(NREQ);
  localparam logic [IDW-1:0] LAST = IDW'(NREQ - 1);

  function automatic logic [BITWIDTH-1:0] clamp_exp(input logic [BITWIDTH-1:0] e);
    return (e > BITWIDTH'(INPUTMAX)) ? BITWIDTH'(INPUTMAX) : e;
  endfunction

  function automatic logic is_sat(input logic [BITWIDTH-1:0] e);
    return e > BITWIDTH'(INPUTMAX);
  endfunction

  logic [IDW-1:0]      ptr;
  logic [IDW-1:0]      cand;
  logic [IDW-1:0]      gnt_idx;
  logic                gnt_found;
  logic                grant;
  logic                can_issue;
  logic                rsp_xfer;
  credit_t             credits;
  logic [BITWIDTH-1:0] exp_raw;
  logic [BITWIDTH-1:0] exp_clamped;
  logic                sat_raw;

  logic [IDW-1:0]      id_p0;
  logic                sat_p0;
  logic [BITWIDTH-1:0] sh_data_p1;
  logic                sh_vld_p1;

  logic [BITWIDTH-1:0] fifo_data [2];
  logic [IDW-1:0]      fifo_id   [2];
  logic                fifo_sat  [2];
  logic                wr_ptr;
  logic                rd_ptr;
  logic [1:0]          count;
  logic                fifo_nempty;

  // Round-robin search starting at ptr.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = IDW'((int'(ptr) + k) % NREQ);
      if (!gnt_found && bus.Req_vld[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  assign fifo_nempty = (count != 2'd0);
  assign rsp_xfer    = fifo_nempty && bus.Rsp_rdy;
  // A departing response frees its credit in the same cycle, sustaining one grant per cycle.
  assign can_issue   = (credits < CREDIT_MAX) || rsp_xfer;
  assign grant       = gnt_found && can_issue && !Reset;
  assign bus.Req_rdy = grant ? (NREQ'(1) << gnt_idx) : '0;

  assign exp_raw     = bus.Req_data[int'(gnt_idx)*BITWIDTH +: BITWIDTH];
  assign exp_clamped = clamp_exp(exp_raw);
  assign sat_raw     = is_sat(exp_raw);

  always_ff @(posedge Clock) begin
    if (Reset) begin
      ptr     <= '0;
      credits <= '0;
    end else begin
      if (grant) ptr <= (gnt_idx == LAST) ? '0 : gnt_idx + 1'b1;
      if (grant && !rsp_xfer)      credits <= credits + 2'd1;
      else if (!grant && rsp_xfer) credits <= credits - 2'd1;
    end
  end

  // ---- stage p0: issue to shifter, tag travels alongside ----
  always_ff @(posedge Clock) begin
    if (Reset) begin
      id_p0  <= '0;
      sat_p0 <= 1'b0;
    end else if (grant) begin
      id_p0  <= gnt_idx;
      sat_p0 <= sat_raw;
    end
  end

  shifter_sched_shifter #(
    .BITWIDTH (BITWIDTH),
    .INPUTMAX (INPUTMAX)
  ) u_shifter (
    .Clock       (Clock),
    .Reset       (Reset),
    .Start       (grant),
    .Datain      (exp_clamped),
    .DataOut     (sh_data_p1),
    .DataOut_vld (sh_vld_p1)
  );

  // ---- stage p1: capture into response FIFO ----
  always_ff @(posedge Clock) begin
    if (Reset) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        fifo_data[i] <= '0;
        fifo_id[i]   <= '0;
        fifo_sat[i]  <= 1'b0;
      end
    end else begin
      if (sh_vld_p1) begin
        fifo_data[wr_ptr] <= sh_data_p1;
        fifo_id[wr_ptr]   <= id_p0;
        fifo_sat[wr_ptr]  <= sat_p0;
        wr_ptr            <= ~wr_ptr;
      end
      if (rsp_xfer) rd_ptr <= ~rd_ptr;
      case ({sh_vld_p1, rsp_xfer})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign bus.Rsp_vld  = fifo_nempty;
  assign bus.Rsp_data = fifo_data[rd_ptr];
  assign bus.Rsp_id   = fifo_id[rd_ptr];
  assign bus.Rsp_sat  = fifo_sat[rd_ptr];
  assign bus.Busy     = (credits != '0);

endmodule

// File: tb/tb_shifter_sched.sv
// Scoreboard bench for shifter_sched: grants push expected responses, a monitor pops and compares.
module tb_shifter_sched;

  logic Clock = 1'b0;
  logic Reset;

  shifter_sched_if #(.BITWIDTH(32), .NREQ(4)) bus ();

  shifter_sched #(.BITWIDTH(32), .NREQ(4), .INPUTMAX(5)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clock = ~Clock;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  id;
    logic        sat;
  } rsp_t;

  rsp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [31:0] pow2_model(input logic [31:0] e);
    logic [7:0] c;
    c = (e > 32'd5) ? 8'd5 : e[7:0];
    return {1'b0, 8'd127 + c, 23'd0};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic set_e(input int i, input logic [31:0] v);
    bus.Req_data[i*32 +: 32] = v;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    @(negedge Clock);
    while (bus.Busy && n < 30) begin
      @(negedge Clock);
      n++;
    end
    checks++;
    if (bus.Busy) begin
      errors++;
      $display("FAIL %s: Busy still 1 after %0d cycles, required 0", name, n);
    end
  endtask

  task automatic wait_rsp(input string name);
    int n = 0;
    @(negedge Clock);
    while (!bus.Rsp_vld && n < 10) begin
      @(negedge Clock);
      n++;
    end
    chk(name, bus.Rsp_vld, 1'b1);
  endtask

  // Grant observer: records the expected response for each accepted request.
  always @(negedge Clock) begin
    if (bus.Req_rdy != '0) begin
      int g;
      logic [31:0] e;
      g = 0;
      for (int i = 0; i < 4; i++) if (bus.Req_rdy[i]) g = i;
      checks++;
      if ($countones(bus.Req_rdy) != 1 || (bus.Req_rdy & bus.Req_vld) == '0) begin
        errors++;
        $display("FAIL grant_onehot: Req_rdy=%b Req_vld=%b, required one-hot within Req_vld",
                 bus.Req_rdy, bus.Req_vld);
      end
      e = bus.Req_data[g*32 +: 32];
      exp_q.push_back('{data: pow2_model(e), id: 2'(g), sat: (e > 32'd5)});
    end
  end

  // Response monitor.
  always @(negedge Clock) begin
    if (bus.Rsp_vld && bus.Rsp_rdy) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_unexpected: got data %h id %0d, required no response",
                 bus.Rsp_data, bus.Rsp_id);
      end else begin
        rsp_t r;
        r = exp_q.pop_front();
        chk("sb_data", bus.Rsp_data, r.data);
        chk("sb_id",   bus.Rsp_id,   r.id);
        chk("sb_sat",  bus.Rsp_sat,  r.sat);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset        = 1'b1;
    bus.Req_vld  = '0;
    bus.Req_data = '0;
    bus.Rsp_rdy  = 1'b0;
    repeat (2) @(posedge Clock);
    #1;
    bus.Req_vld = 4'b1111;
    @(negedge Clock);
    chk("rst_req_rdy",  bus.Req_rdy,  4'b0000);
    chk("rst_rsp_vld",  bus.Rsp_vld,  1'b0);
    chk("rst_rsp_data", bus.Rsp_data, 32'h0);
    chk("rst_rsp_id",   bus.Rsp_id,   2'd0);
    chk("rst_rsp_sat",  bus.Rsp_sat,  1'b0);
    chk("rst_busy",     bus.Busy,     1'b0);

    // Single request, grant in first cycle after reset.
    tick();
    Reset       = 1'b0;
    bus.Req_vld = 4'b0001;
    bus.Req_data = '0;
    set_e(0, 32'd3);
    bus.Rsp_rdy = 1'b1;
    @(negedge Clock);
    chk("single_grant", bus.Req_rdy, 4'b0001);
    tick();
    bus.Req_vld = '0;
    @(negedge Clock);
    chk("single_vld_c1",  bus.Rsp_vld, 1'b0);
    chk("single_busy_c1", bus.Busy,    1'b1);
    tick();
    @(negedge Clock);
    chk("single_vld_c2",  bus.Rsp_vld,  1'b1);
    chk("single_data_c2", bus.Rsp_data, 32'h41000000);
    chk("single_id_c2",   bus.Rsp_id,   2'd0);
    chk("single_sat_c2",  bus.Rsp_sat,  1'b0);
    tick();
    @(negedge Clock);
    chk("single_busy_c3", bus.Busy,    1'b0);
    chk("single_vld_c3",  bus.Rsp_vld, 1'b0);

    // Clamp on requester 2.
    tick();
    bus.Req_vld = 4'b0100;
    set_e(2, 32'd9);
    @(negedge Clock);
    chk("clamp_grant", bus.Req_rdy, 4'b0100);
    tick();
    bus.Req_vld = '0;
    wait_rsp("clamp_vld");
    chk("clamp_data", bus.Rsp_data, 32'h42000000);
    chk("clamp_id",   bus.Rsp_id,   2'd2);
    chk("clamp_sat",  bus.Rsp_sat,  1'b1);
    wait_idle("clamp_idle");

    // Reset pulse so the pointer restarts at 0, then fairness.
    tick();
    Reset = 1'b1;
    exp_q.delete();
    tick();
    Reset = 1'b0;
    for (int i = 0; i < 4; i++) set_e(i, 32'(i + 1));
    bus.Req_vld = 4'b1111;
    bus.Rsp_rdy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge Clock);
      chk("fair_grant", bus.Req_rdy, 4'b0001 << (i % 4));
      tick();
    end
    bus.Req_vld = '0;
    wait_idle("fair_idle");

    // Backpressure: two grants, stall, then resume with grant+transfer at full credits.
    tick();
    bus.Rsp_rdy = 1'b0;
    set_e(0, 32'd0);
    set_e(1, 32'd6);
    set_e(2, 32'd2);
    set_e(3, 32'd7);
    bus.Req_vld = 4'b1111;
    @(negedge Clock);
    chk("bp_grant0", bus.Req_rdy, 4'b0001);
    tick();
    @(negedge Clock);
    chk("bp_grant1", bus.Req_rdy, 4'b0010);
    tick();
    for (int i = 0; i < 4; i++) begin
      @(negedge Clock);
      chk("bp_stall", bus.Req_rdy, 4'b0000);
      tick();
    end
    @(negedge Clock);
    chk("bp_busy",  bus.Busy,     1'b1);
    chk("bp_head",  bus.Rsp_data, 32'h3f800000);
    tick();
    bus.Rsp_rdy = 1'b1;
    @(negedge Clock);
    chk("bp_resume2", bus.Req_rdy, 4'b0100);
    tick();
    chk("bp_credits", dut.credits, 2'd2);
    @(negedge Clock);
    chk("bp_resume3", bus.Req_rdy, 4'b1000);
    tick();
    bus.Req_vld = '0;
    wait_idle("bp_idle");
    chk("bp_sb_empty", exp_q.size(), 0);

    // Reset with two results buffered.
    tick();
    bus.Rsp_rdy = 1'b0;
    set_e(0, 32'd1);
    set_e(1, 32'd1);
    bus.Req_vld = 4'b0011;
    @(negedge Clock);
    chk("rb_grant0", bus.Req_rdy, 4'b0001);
    tick();
    @(negedge Clock);
    chk("rb_grant1", bus.Req_rdy, 4'b0010);
    tick();
    bus.Req_vld = '0;
    tick();
    tick();
    @(negedge Clock);
    chk("rb_full_vld", bus.Rsp_vld, 1'b1);
    Reset = 1'b1;
    exp_q.delete();
    tick();
    Reset = 1'b0;
    bus.Rsp_rdy = 1'b1;
    @(negedge Clock);
    chk("rb_vld",  bus.Rsp_vld, 1'b0);
    chk("rb_busy", bus.Busy,    1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      @(negedge Clock);
      chk("rb_quiet", bus.Rsp_vld, 1'b0);
    end

    // Fresh grant after reset works normally.
    tick();
    set_e(3, 32'd0);
    bus.Req_vld = 4'b1000;
    @(negedge Clock);
    chk("post_grant", bus.Req_rdy, 4'b1000);
    tick();
    bus.Req_vld = '0;
    wait_rsp("post_vld");
    chk("post_data", bus.Rsp_data, 32'h3f800000);
    chk("post_id",   bus.Rsp_id,   2'd3);
    wait_idle("post_idle");
    chk("final_sb_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
